// File: rtl/aes_iter_ctrl_if.sv
// aes_iter_ctrl_if: input/output handshakes and round-datapath signals of the AES-128 iterative controller
interface aes_iter_ctrl_if;
  logic         in_valid, in_ready, rnd_last, out_valid, out_ready;
  logic [127:0] in_data, in_key, rnd_state, rnd_key, key_next, rnd_result, out_data;
  logic [3:0]   rnd_idx;
  modport slave (
    input  in_valid, in_data, in_key, key_next, rnd_result, out_ready,
    output in_ready, rnd_state, rnd_key, rnd_idx, rnd_last, out_valid, out_data
  );
  modport master (
    output in_valid, in_data, in_key, key_next, rnd_result, out_ready,
    input  in_ready, rnd_state, rnd_key, rnd_idx, rnd_last, out_valid, out_data
  );
endinterface

// File: rtl/aes_iter_ctrl.sv
// aes_iter_ctrl: AES-128 round sequencer (IDLE/ROUND/DONE); define AES_ITER_CTRL_B2B_EN to accept a new pair on the output handshake edge
module aes_iter_ctrl (
  input  logic           clk,
  input  logic           reset,
  aes_iter_ctrl_if.slave bus,
  output logic           busy_o,
  output logic [15:0]    blk_cnt_o
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;
  fsm_t         fsm_q;
  logic [127:0] state_q, key_q, out_q;
  logic [3:0]   idx_q;
  logic [15:0]  blk_cnt_q;
  logic         accept;
`ifdef AES_ITER_CTRL_B2B_EN
  assign bus.in_ready = !reset && (fsm_q == IDLE || (fsm_q == DONE && bus.out_ready));
`else
  assign bus.in_ready = !reset && fsm_q == IDLE;
`endif
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.rnd_state = state_q;
  assign bus.rnd_key   = key_q;
  assign bus.rnd_idx   = idx_q;
  assign bus.rnd_last  = idx_q == 4'd10;
  assign bus.out_valid = fsm_q == DONE;
  assign bus.out_data  = out_q;
  assign busy_o        = fsm_q != IDLE;
  assign blk_cnt_o     = blk_cnt_q;
  // Accept a pair (initial AddRoundKey), run rounds 1..10, then hold the ciphertext until consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q     <= IDLE;
      state_q   <= '0;
      key_q     <= '0;
      out_q     <= '0;
      idx_q     <= '0;
      blk_cnt_q <= '0;
    end else begin
      if (accept) begin
        state_q <= bus.in_data ^ bus.in_key;
        key_q   <= bus.in_key;
        idx_q   <= 4'd1;
      end
      case (fsm_q)
        IDLE: if (accept) fsm_q <= ROUND;
        ROUND: begin
          if (idx_q > 4'd10) begin
            fsm_q <= IDLE;
            idx_q <= '0;
          end else begin
            key_q   <= bus.key_next;
            state_q <= bus.rnd_result;
            idx_q   <= idx_q == 4'd10 ? 4'd0 : idx_q + 4'd1;
            if (idx_q == 4'd10) begin
              out_q <= bus.rnd_result;
              fsm_q <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            blk_cnt_q <= blk_cnt_q + 16'd1;
            fsm_q     <= accept ? ROUND : IDLE;
          end
        end
        default: begin
          fsm_q <= IDLE;
          idx_q <= '0;
        end
      endcase
    end
  end
endmodule
